pipelined_n_input_mux: RTL

- Parametrised successor to the fixed 8-input, 3-bit-select datapath mux.
- Selects one of INPUTS words of BITS width.
- The reduction tree is split into registered pipeline stages, with valid/ready flow control and an out-of-range select flag.
- Used on wide operand/forwarding selects where a single-cycle tree would break timing.

---
 rtl/mux_pkg.sv | 27 ++
 rtl/n_bits_mux_tree_stage.sv | 79 +++++++
 rtl/pipelined_n_input_mux.sv | 110 +++++++++++
 3 files changed

// File: rtl/mux_pkg.sv
// mux_pkg
//   Shared sizing helpers for the pipelined N-input mux.
//   ceil_div     : integer ceiling division.
//   sel_width    : select width for a given input count, ceil(log2(inputs)), minimum 1.
//   stage_count  : register stages needed when each stage folds 'lps' tree levels.
//   MAX_INPUTS   : largest supported input count.
package mux_pkg;

  localparam int MAX_INPUTS = 256;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // A 2-input mux still needs one select bit, so the width never drops below 1.
  function automatic int sel_width(input int inputs);
    int w;
    w = 0;
    while ((1 << w) < inputs) w++;
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int stage_count(input int sel_w, input int lps);
    return ceil_div(sel_w, lps);
  endfunction

endpackage

// File: rtl/n_bits_mux_tree_stage.sv
// n_bits_mux_tree_stage
//   One registered slice of the mux reduction tree. Folds IN_WORDS words down to
//   IN_WORDS / 2^LEVELS words using the low LEVELS bits of the select remnant,
//   and carries the unused upper select bits, valid and error bits alongside.
//   Ports:
//     clock, reset         : rising-edge clock, synchronous active-high reset
//     en                   : stage captures new contents only when high
//     valid_in / valid_out : beat qualifier in / registered out
//     err_in / err_out     : out-of-range select flag in / registered out
//     sel_in / sel_out     : select remnant in / remnant shifted down by LEVELS
//     data_in / data_out   : IN_WORDS words in / OUT_WORDS registered words out
module n_bits_mux_tree_stage
  import mux_pkg::*;
#(
  parameter int BITS      = 32,
  parameter int IN_WORDS  = 4,
  parameter int LEVELS    = 2,
  parameter int SEL_W     = 2,
  localparam int OUT_WORDS = IN_WORDS >> LEVELS
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           en,
  input  logic                           valid_in,
  input  logic                           err_in,
  input  logic [SEL_W-1:0]               sel_in,
  input  logic [IN_WORDS-1:0][BITS-1:0]  data_in,
  output logic                           valid_out,
  output logic                           err_out,
  output logic [SEL_W-1:0]               sel_out,
  output logic [OUT_WORDS-1:0][BITS-1:0] data_out
);

  logic                           valid_q, valid_d;
  logic                           err_q, err_d;
  logic [SEL_W-1:0]               sel_q, sel_d;
  logic [OUT_WORDS-1:0][BITS-1:0] data_q, data_d;
  logic [LEVELS-1:0]              idx;

  assign idx = sel_in[LEVELS-1:0];

  // Each output word j picks one of its 2^LEVELS consecutive input words; the
  // remaining select bits are shifted down so the next stage sees them at bit 0.
  always_comb begin
    valid_d = valid_q;
    err_d   = err_q;
    sel_d   = sel_q;
    data_d  = data_q;
    if (en) begin
      valid_d = valid_in;
      err_d   = err_in;
      sel_d   = sel_in >> LEVELS;
      for (int j = 0; j < OUT_WORDS; j++) begin
        data_d[j] = data_in[j * (1 << LEVELS) + int'(idx)];
      end
    end
  end

  // Reset wipes the stage so no in-flight beat survives it.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      sel_q   <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      err_q   <= err_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
    end
  end

  assign valid_out = valid_q;
  assign err_out   = err_q;
  assign sel_out   = sel_q;
  assign data_out  = data_q;

endmodule

// File: rtl/pipelined_n_input_mux.sv
// pipelined_n_input_mux
//   Selects one of INPUTS words of BITS width through a mux tree broken into
//   STAGES register stages, LEVELS_PER_STAGE 2:1 levels each, with valid/ready
//   flow control and an out-of-range select flag.
//   Ports:
//     CLK, RESET          : rising-edge clock, synchronous active-high reset
//     IN_VALID / IN_READY : input handshake (IN_READY depends on OUT_READY)
//     DATA                : INPUTS packed words
//     SELECT              : index of the word to forward
//     OUT_VALID/OUT_READY : output handshake
//     OUT                 : selected word (0 for an out-of-range select)
//     SEL_ERR             : the beat's SELECT was >= INPUTS
module pipelined_n_input_mux
  import mux_pkg::*;
#(
  parameter int BITS             = 32,
  parameter int INPUTS           = 8,
  parameter int LEVELS_PER_STAGE = 2,
  localparam int SEL_W  = sel_width(INPUTS),
  localparam int STAGES = stage_count(SEL_W, LEVELS_PER_STAGE)
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic                         IN_VALID,
  output logic                         IN_READY,
  input  logic [INPUTS-1:0][BITS-1:0]  DATA,
  input  logic [SEL_W-1:0]             SELECT,
  output logic                         OUT_VALID,
  input  logic                         OUT_READY,
  output logic [BITS-1:0]              OUT,
  output logic                         SEL_ERR
);

  localparam int LEAVES = 1 << SEL_W;

  logic                               adv;
  logic                               in_err;
  logic [LEAVES-1:0][BITS-1:0]        leaves;
  logic [STAGES:1]                    valid_s;
  logic [STAGES:1]                    err_s;
  logic [STAGES:1][SEL_W-1:0]         sel_s;
  logic [STAGES:1][LEAVES-1:0][BITS-1:0] data_s;

  // The whole pipe moves as one: it advances whenever the output slot is empty
  // or being drained, and never during reset.
  assign adv      = ~RESET & (OUT_READY | ~OUT_VALID);
  assign IN_READY = adv;

  // Pad the tree to a power of two with zero leaves so out-of-range selects
  // naturally land on zero; bubbles are zeroed too so OUT never carries junk.
  always_comb begin
    leaves = '0;
    for (int i = 0; i < INPUTS; i++) begin
      if (IN_VALID) leaves[i] = DATA[i];
    end
  end

  assign in_err = IN_VALID & (int'(SELECT) >= INPUTS);

  for (genvar s = 1; s <= STAGES; s++) begin : g_stage
    // The last stage may have fewer select bits left than a full stage folds.
    localparam int REMAINING = SEL_W - (s - 1) * LEVELS_PER_STAGE;
    localparam int LEVELS    = (REMAINING < LEVELS_PER_STAGE) ? REMAINING : LEVELS_PER_STAGE;
    localparam int IN_WORDS  = 1 << REMAINING;
    localparam int OUT_WORDS = IN_WORDS >> LEVELS;

    logic                          st_valid;
    logic                          st_err;
    logic [SEL_W-1:0]              st_sel;
    logic [IN_WORDS-1:0][BITS-1:0] st_data;

    if (s == 1) begin : g_head
      assign st_valid = IN_VALID;
      assign st_err   = in_err;
      assign st_sel   = SELECT;
      assign st_data  = leaves[IN_WORDS-1:0];
    end else begin : g_tail
      assign st_valid = valid_s[s-1];
      assign st_err   = err_s[s-1];
      assign st_sel   = sel_s[s-1];
      assign st_data  = data_s[s-1][IN_WORDS-1:0];
    end

    n_bits_mux_tree_stage #(
      .BITS     (BITS),
      .IN_WORDS (IN_WORDS),
      .LEVELS   (LEVELS),
      .SEL_W    (SEL_W)
    ) u_stage (
      .clock     (CLK),
      .reset     (RESET),
      .en        (adv),
      .valid_in  (st_valid),
      .err_in    (st_err),
      .sel_in    (st_sel),
      .data_in   (st_data),
      .valid_out (valid_s[s]),
      .err_out   (err_s[s]),
      .sel_out   (sel_s[s]),
      .data_out  (data_s[s][OUT_WORDS-1:0])
    );

    assign data_s[s][LEAVES-1:OUT_WORDS] = '0;
  end

  assign OUT_VALID = valid_s[STAGES];
  assign SEL_ERR   = err_s[STAGES];
  assign OUT       = data_s[STAGES][0];

endmodule
